// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative ALU: operation and FSM state
// enums, opcode/func7 encodings, and operation-class helpers.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_M   = 7'b0000001;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  function automatic logic is_mul(input op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div(input op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_quot(input op_e op);
    return op inside {ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied combinationally for FIX.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  op_e                 op_q, op_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [SHW:0]        cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic                sa, sb;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      sum, shifted, diff;
  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]    quo, rem;

  always_comb begin
    sa    = (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a[WIDTH-1];
    sb    = (op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM}) && b[WIDTH-1];
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;

    // acc holds {high product, multiplier} for MUL and {remainder, quotient} for DIV
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shifted = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, mcand_q};

    op_d      = op_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    if (start) begin
      op_d      = op;
      mcand_d   = is_mul(op) ? a_mag : b_mag;
      acc_d     = {{WIDTH{1'b0}}, is_mul(op) ? b_mag : a_mag};
      cnt_d     = (SHW+1)'(WIDTH);
      neg_res_d = sa ^ sb;
      neg_rem_d = sa;
    end else if (step) begin
      cnt_d = cnt_q - 1'b1;
      if (is_mul(op_q))
        acc_d = {sum, acc_q[WIDTH-1:1]};
      else if (shifted >= {1'b0, mcand_q})
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= ALU_ADD;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign last = step && (cnt_q == (SHW+1)'(1));

  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    unique case (op_q)
      ALU_MUL:                        result = prod[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:              result = quo;
      default:                        result = rem;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU with valid/ready handshake: single-cycle RV32I ops plus
// iterative RV32M multiply/divide through iter_muldiv.
module iter_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             aluSrc,
  input  logic [1:0]       aluOper,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] readRegister1,
  input  logic [WIDTH-1:0] readRegister2,
  input  logic [WIDTH-1:0] extendedImmediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] arithResult,
  output logic             isZero
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  op_e              op;
  logic [6:0]       opcode, func7;
  logic [2:0]       func3;
  logic [WIDTH-1:0] opa, opb, alu_res, spec_res, md_result;
  logic [SHW-1:0]   shamt;
  logic             div_zero, div_ovf, md_start, md_step, md_last;
  logic             unused_instr;

  assign opcode       = instruction[6:0];
  assign func3        = instruction[14:12];
  assign func7        = instruction[31:25];
  assign unused_instr = ^{instruction[24:15], instruction[11:7]};
  assign opa          = readRegister1;
  assign opb          = aluSrc ? extendedImmediate : readRegister2;
  assign shamt        = opb[SHW-1:0];

  always_comb begin
    op = ALU_ADD;
    if (aluOper == 2'b01) begin
      op = ALU_SUB;
    end else if (aluOper == 2'b10) begin
      if (opcode == OP_R && func7 == F7_M) begin
        unique case (func3)
          3'd0: op = ALU_MUL;
          3'd1: op = ALU_MULH;
          3'd2: op = ALU_MULHSU;
          3'd3: op = ALU_MULHU;
          3'd4: op = ALU_DIV;
          3'd5: op = ALU_DIVU;
          3'd6: op = ALU_REM;
          default: op = ALU_REMU;
        endcase
      end else if (opcode == OP_R || opcode == OP_I) begin
        unique case (func3)
          3'd0: op = (opcode == OP_R && func7[5]) ? ALU_SUB : ALU_ADD;
          3'd1: op = ALU_SLL;
          3'd2: op = ALU_SLT;
          3'd3: op = ALU_SLTU;
          3'd4: op = ALU_XOR;
          3'd5: op = func7[5] ? ALU_SRA : ALU_SRL;
          3'd6: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
    end
  end

  always_comb begin
    unique case (op)
      ALU_SUB:  alu_res = opa - opb;
      ALU_SLL:  alu_res = opa << shamt;
      ALU_SLT:  alu_res = WIDTH'($signed(opa) < $signed(opb));
      ALU_SLTU: alu_res = WIDTH'(opa < opb);
      ALU_XOR:  alu_res = opa ^ opb;
      ALU_SRL:  alu_res = opa >> shamt;
      ALU_SRA:  alu_res = $signed(opa) >>> shamt;
      ALU_OR:   alu_res = opa | opb;
      ALU_AND:  alu_res = opa & opb;
      default:  alu_res = opa + opb;
    endcase
  end

  // Divide corner cases bypass the iterative datapath entirely
  always_comb begin
    div_zero = (opb == '0);
    div_ovf  = (op == ALU_DIV || op == ALU_REM) && opa == MIN_NEG && opb == '1;
    if (div_zero)
      spec_res = is_quot(op) ? '1 : opa;
    else
      spec_res = is_quot(op) ? opa : '0;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    md_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mul(op)) begin
            md_start = 1'b1;
            state_d  = ST_MUL;
          end else if (is_div(op) && !(div_zero || div_ovf)) begin
            md_start = 1'b1;
            state_d  = ST_DIV;
          end else begin
            result_d = is_div(op) ? spec_res : alu_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: if (md_last) state_d = ST_FIX;
      ST_FIX: begin
        result_d = md_result;
        state_d  = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign md_step     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign arithResult = result_q;
  assign isZero      = zero_q;

  iter_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .op      (op),
    .a       (opa),
    .b       (opb),
    .step    (md_step),
    .last    (md_last),
    .result  (md_result)
  );

endmodule

// File: tb/tb_iter_alu.sv
// Randomised and directed checks of iter_alu against a 64-bit arithmetic
// reference model of the RV32I/RV32M operation set.
module tb_iter_alu;

  localparam logic [6:0] R_T = 7'b0110011;
  localparam logic [6:0] I_T = 7'b0010011;
  localparam int LONG_LAT = 34;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        aluSrc = 1'b0;
  logic [1:0]  aluOper = 2'b00;
  logic [31:0] instruction = '0;
  logic [31:0] readRegister1 = '0;
  logic [31:0] readRegister2 = '0;
  logic [31:0] extendedImmediate = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] arithResult;
  logic        isZero;

  int checks = 0;
  int errors = 0;

  iter_alu #(.WIDTH(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .aluSrc            (aluSrc),
    .aluOper           (aluOper),
    .instruction       (instruction),
    .readRegister1     (readRegister1),
    .readRegister2     (readRegister2),
    .extendedImmediate (extendedImmediate),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .arithResult       (arithResult),
    .isZero            (isZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [6:0] opc);
    return {f7, 10'b0, f3, 5'b0, opc};
  endfunction

  function automatic logic [31:0] model(input logic [1:0] oper, input logic [31:0] ins,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    longint      sa, sb;
    logic [63:0] p;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    sh  = b[4:0];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (oper == 2'b01) return a - b;
    if (oper != 2'b10 || (opc != R_T && opc != I_T)) return a + b;
    if (opc == R_T && f7 == 7'b0000001) begin
      case (f3)
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * longint'(b); return p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        3'd4: begin
          if (b == 0) return '1;
          p = sa / sb;
          return p[31:0];
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          p = sa % sb;
          return p[31:0];
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: return (opc == R_T && f7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return {31'b0, sa < sb};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: begin
        if (!f7[5]) return a >> sh;
        p = sa >>> sh;
        return p[31:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] oper, input logic [31:0] ins,
                                   input logic [31:0] a, input logic [31:0] b);
    if (oper != 2'b10 || ins[6:0] != R_T || ins[31:25] != 7'b0000001) return 1;
    if (ins[14:12] < 3'd4) return LONG_LAT;
    if (b == 0) return 1;
    if ((ins[14:12] == 3'd4 || ins[14:12] == 3'd6) && a == 32'h8000_0000 && b == '1) return 1;
    return LONG_LAT;
  endfunction

  task automatic issue(input logic [1:0] oper, input logic src, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] rb, input logic [31:0] imm);
    aluOper           = oper;
    aluSrc            = src;
    instruction       = ins;
    readRegister1     = a;
    readRegister2     = rb;
    extendedImmediate = imm;
    in_valid          = 1'b1;
    @(posedge clk); #1;
    in_valid          = 1'b0;
    // scramble inputs: the block must have latched everything it needs
    aluOper           = 2'($urandom);
    aluSrc            = 1'($urandom);
    instruction       = $urandom;
    readRegister1     = $urandom;
    readRegister2     = $urandom;
    extendedImmediate = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [1:0] oper, input logic src,
                        input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rb,
                        input logic [31:0] imm, input int hold, output logic [31:0] got);
    logic [31:0] b, exp;
    int lat_exp, n, cyc;
    b       = src ? imm : rb;
    exp     = model(oper, ins, a, b);
    lat_exp = model_lat(oper, ins, a, b);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "/in_ready_before"}, in_ready, 1);
    issue(oper, src, ins, a, rb, imm);
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check({tag, "/latency"}, cyc, lat_exp);
    check({tag, "/result"}, arithResult, exp);
    check({tag, "/isZero"}, isZero, exp == 0);
    check({tag, "/in_ready_busy"}, in_ready, 0);
    got = arithResult;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_result"}, arithResult, exp);
      check({tag, "/hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, out_valid, 0);
    check({tag, "/in_ready_back"}, in_ready, 1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] got, ins;
    logic [6:0]  opc, f7;
    logic [1:0]  oper;
    int k;

    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", in_ready, 1);
    check("reset/out_valid", out_valid, 0);
    check("reset/result", arithResult, 0);
    check("reset/isZero", isZero, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of a multiply aborts it
    issue(2'b10, 1'b0, mk_instr(7'b0000001, 3'd1, R_T), 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    check("midreset/in_ready", in_ready, 1);
    check("midreset/out_valid", out_valid, 0);
    check("midreset/result", arithResult, 0);
    check("midreset/isZero", isZero, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("postreset/out_valid", out_valid, 0);

    run_op("add", 2'b10, 1'b0, mk_instr(7'b0, 3'd0, R_T), 7, 5, 0, 0, got);
    check("add/const", got, 32'd12);
    run_op("sub", 2'b10, 1'b0, mk_instr(7'b0100000, 3'd0, R_T), 5, 7, 0, 0, got);
    check("sub/const", got, 32'hFFFF_FFFE);
    run_op("sub_eq", 2'b10, 1'b0, mk_instr(7'b0100000, 3'd0, R_T), 9, 9, 0, 0, got);
    check("sub_eq/const", got, 32'h0);
    run_op("srai", 2'b10, 1'b1, mk_instr(7'b0100000, 3'd5, I_T), 32'h8000_0000, 0, 4, 0, got);
    check("srai/const", got, 32'hF800_0000);
    run_op("srli", 2'b10, 1'b1, mk_instr(7'b0, 3'd5, I_T), 32'h8000_0000, 0, 4, 0, got);
    check("srli/const", got, 32'h0800_0000);
    run_op("mulh", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd1, R_T), 32'hFFFF_FFFF, 2, 0, 0, got);
    check("mulh/const", got, 32'hFFFF_FFFF);
    run_op("mulhu", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd3, R_T), 32'hFFFF_FFFF, 2, 0, 0, got);
    check("mulhu/const", got, 32'h1);
    run_op("div_ovf", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd4, R_T), 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, got);
    check("div_ovf/const", got, 32'h8000_0000);
    run_op("rem_ovf", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd6, R_T), 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, got);
    check("rem_ovf/const", got, 32'h0);
    run_op("divu_0", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd5, R_T), 32'h1234, 0, 0, 0, got);
    check("divu_0/const", got, 32'hFFFF_FFFF);
    run_op("remu_0", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd7, R_T), 9, 0, 0, 0, got);
    check("remu_0/const", got, 32'd9);
    run_op("div_bp", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd4, R_T), -32'sd7, 2, 0, 5, got);
    check("div_bp/const", got, 32'hFFFF_FFFD);
    run_op("rem_neg", 2'b10, 1'b0, mk_instr(7'b0000001, 3'd6, R_T), -32'sd7, 2, 0, 0, got);
    check("rem_neg/const", got, 32'hFFFF_FFFF);

    for (int t = 0; t < 60; t++) begin
      k   = $urandom_range(0, 9);
      opc = (k < 6) ? R_T : (k < 9) ? I_T : 7'b0000011;
      case ($urandom_range(0, 3))
        0: f7 = 7'b0;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      ins  = mk_instr(f7, 3'($urandom), opc);
      k    = $urandom_range(0, 5);
      oper = (k > 3) ? 2'b10 : 2'(k);
      run_op($sformatf("rand%0d", t), oper, 1'($urandom), ins, pick_val(), pick_val(),
             pick_val(), $urandom_range(0, 3), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
